// File: rtl/ar_mrd_splitter.sv
// Splits AXI read-address bursts into PCIe MRd headers bounded by MRRS (and hence by 4 KB).
// Optional build macro AR_MRD_TAG_CREDIT_EN adds an outstanding-tag credit limit (TAG_CREDITS).

package PCIE_PKG;
  localparam int ADDR_WIDTH = 64;
endpackage

interface AXI4_A_IF #(
  parameter int ADDR_WIDTH = PCIE_PKG::ADDR_WIDTH,
  parameter int ID_WIDTH   = 4
);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;

  modport master (output avalid, aid, aaddr, alen, input aready);
  modport slave  (input avalid, aid, aaddr, alen, output aready);
endinterface

module ar_mrd_splitter #(
  parameter int          ADDR_WIDTH  = PCIE_PKG::ADDR_WIDTH,
  parameter int          ID_WIDTH    = 4,
  parameter int          BEAT_BYTES  = 32,
  parameter int          MRRS_BYTES  = 256,
  parameter int          TAG_WIDTH   = 8,
  parameter logic [15:0] REQ_ID      = 16'h0000,
  parameter int          TAG_CREDITS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  AXI4_A_IF.slave                       ar_if,
  input  logic                          hdr_fifo_afull,
  output logic                          hdr_fifo_wren,
  output logic [127:0]                  hdr_fifo_data,
  output logic                          tag_fifo_wren,
  output logic [ID_WIDTH+TAG_WIDTH:0]   tag_fifo_data,
  input  logic                          tag_release,
  output logic                          busy
);

  localparam int BEAT_LSB = $clog2(BEAT_BYTES);
  localparam int MRRS_LSB = $clog2(MRRS_BYTES);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [13:0]             remaining_q, remaining_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [ID_WIDTH-1:0]     aid_q, aid_d;

  logic [13:0]             room, chunk;
  logic [9:0]              len_dw;
  logic [63:0]             addr64;
  logic                    last_chunk, issue, credit_ok;
  logic [127:0]            hdr_d;
  logic [ID_WIDTH+TAG_WIDTH:0] tag_data_d;

  assign ar_if.aready = (state_q == IDLE) && !rst;
  assign busy         = (state_q == SPLIT);

  // Bytes left before the next MRRS-aligned boundary; MRRS divides 4 KB so 4 KB is never crossed.
  assign room       = 14'(MRRS_BYTES) - 14'(cur_addr_q[MRRS_LSB-1:0]);
  assign chunk      = (remaining_q < room) ? remaining_q : room;
  assign last_chunk = (remaining_q == chunk);
  assign len_dw     = chunk[11:2];
  assign addr64     = 64'(cur_addr_q);

  assign hdr_d = {addr64[31:0] & 32'hFFFF_FFFC,
                  addr64[63:32],
                  REQ_ID, 8'(tag_q), (len_dw == 10'd1) ? 4'h0 : 4'hF, 4'hF,
                  3'b001, 5'b00000, 14'd0, len_dw};
  assign tag_data_d = {aid_q, tag_q, last_chunk};

`ifdef AR_MRD_TAG_CREDIT_EN
  localparam int CW = $clog2(TAG_CREDITS + 1);
  logic [CW-1:0] credits_q;

  assign credit_ok = (credits_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CW'(TAG_CREDITS);
    end else if (issue && !tag_release) begin
      credits_q <= credits_q - 1'b1;
    end else if (tag_release && !issue && (credits_q != CW'(TAG_CREDITS))) begin
      credits_q <= credits_q + 1'b1;
    end
  end
`else
  logic unused_tag_release;
  assign unused_tag_release = tag_release;
  assign credit_ok          = 1'b1;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    tag_d       = tag_q;
    aid_d       = aid_q;
    issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ar_if.avalid) begin
          aid_d       = ar_if.aid;
          cur_addr_d  = ar_if.aaddr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
          remaining_d = (14'(ar_if.alen) + 14'd1) << BEAT_LSB;
          state_d     = SPLIT;
        end
      end
      SPLIT: begin
        if (!hdr_fifo_afull && credit_ok) begin
          issue       = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(chunk);
          remaining_d = remaining_q - chunk;
          tag_d       = tag_q + 1'b1;
          if (last_chunk) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      tag_q         <= '0;
      aid_q         <= '0;
      hdr_fifo_wren <= 1'b0;
      tag_fifo_wren <= 1'b0;
      hdr_fifo_data <= '0;
      tag_fifo_data <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      tag_q         <= tag_d;
      aid_q         <= aid_d;
      hdr_fifo_wren <= issue;
      tag_fifo_wren <= issue;
      if (issue) begin
        hdr_fifo_data <= hdr_d;
        tag_fifo_data <= tag_data_d;
      end
    end
  end

endmodule

// File: tb/tb_ar_mrd_splitter.sv
// Self-checking bench for ar_mrd_splitter: burst-level scoreboard model plus literal pins.
module tb_ar_mrd_splitter;
  localparam int AW   = 64;
  localparam int IW   = 4;
  localparam int BB   = 32;
  localparam int MRRS = 256;
  localparam int TW   = 8;
  localparam logic [15:0] RID = 16'hBEEF;
`ifdef AR_MRD_TAG_CREDIT_EN
  localparam int TC = 2;
`else
  localparam int TC = 32;
`endif
  localparam int TDW = IW + TW + 1;

  typedef struct packed {
    logic [127:0]    hdr;
    logic [TDW-1:0]  td;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           hdr_fifo_afull;
  logic           hdr_fifo_wren;
  logic [127:0]   hdr_fifo_data;
  logic           tag_fifo_wren;
  logic [TDW-1:0] tag_fifo_data;
  logic           tag_release;
  logic           busy;
  logic           auto_release;
  logic           man_release;

  AXI4_A_IF #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) ar_if ();

  ar_mrd_splitter #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BEAT_BYTES(BB), .MRRS_BYTES(MRRS),
    .TAG_WIDTH(TW), .REQ_ID(RID), .TAG_CREDITS(TC)
  ) dut (
    .clk(clk), .rst(rst), .ar_if(ar_if),
    .hdr_fifo_afull(hdr_fifo_afull), .hdr_fifo_wren(hdr_fifo_wren), .hdr_fifo_data(hdr_fifo_data),
    .tag_fifo_wren(tag_fifo_wren), .tag_fifo_data(tag_fifo_data),
    .tag_release(tag_release), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int unsigned m_tag = 0;
  ent_t exp_q[$];
  ent_t obs_q[$];
  int   obs_cyc[$];

  always @(posedge clk) cyc++;

  // Returns every retired header's tag one cycle later unless a test drives releases by hand.
  always @(posedge clk) begin
    #1 tag_release = (auto_release && hdr_fifo_wren) || man_release;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Whole-burst model: expected headers derived from address arithmetic alone.
  task automatic model_burst(input logic [IW-1:0] id, input logic [63:0] addr, input logic [7:0] alen);
    logic [63:0] a;
    int rem, room, ch, dw;
    ent_t e;
    a   = addr & ~64'(BB - 1);
    rem = (int'(alen) + 1) * BB;
    while (rem > 0) begin
      room = MRRS - int'(a % 64'(MRRS));
      ch   = (rem < room) ? rem : room;
      dw   = (ch / 4) % 1024;
      e.hdr[31:0]   = {3'b001, 5'b00000, 14'd0, 10'(dw)};
      e.hdr[63:32]  = {RID, 8'(m_tag), (dw == 1) ? 4'h0 : 4'hF, 4'hF};
      e.hdr[95:64]  = a[63:32];
      e.hdr[127:96] = {a[31:2], 2'b00};
      e.td          = {id, TW'(m_tag), (rem == ch)};
      exp_q.push_back(e);
      m_tag = (m_tag + 1) % (1 << TW);
      a   = a + 64'(ch);
      rem = rem - ch;
    end
  endtask

  // Per-cycle compare; prev_* hold the inputs the DUT sampled at the edge just passed.
  logic [127:0]   prev_hdr;
  logic [TDW-1:0] prev_td;
  logic           prev_rst   = 1'b1;
  logic           prev_afull = 1'b0;

  always @(negedge clk) begin : cmp
    ent_t e;
    if (prev_rst) begin
      check("rst_wren", {hdr_fifo_wren, tag_fifo_wren}, 0);
      check("rst_hdr", hdr_fifo_data, 0);
      check("rst_td", tag_fifo_data, 0);
      check("rst_busy", busy, 0);
      exp_q.delete();
      m_tag = 0;
    end else if (hdr_fifo_wren) begin
      check("wren_pair", tag_fifo_wren, 1);
      check("afull_hold", prev_afull, 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_hdr: got %h want none", hdr_fifo_data);
      end else begin
        e = exp_q.pop_front();
        check("hdr", hdr_fifo_data, e.hdr);
        check("td", tag_fifo_data, e.td);
      end
      obs_q.push_back({hdr_fifo_data, tag_fifo_data});
      obs_cyc.push_back(cyc);
    end else begin
      check("td_wren_idle", tag_fifo_wren, 0);
      check("hdr_stable", hdr_fifo_data, prev_hdr);
      check("td_stable", tag_fifo_data, prev_td);
    end
    prev_hdr   = hdr_fifo_data;
    prev_td    = tag_fifo_data;
    prev_rst   = rst;
    prev_afull = hdr_fifo_afull;
  end

  task automatic send_ar(input logic [IW-1:0] id, input logic [63:0] addr, input logic [7:0] len);
    bit hs;
    int guard;
    hs = 0;
    guard = 0;
    ar_if.avalid = 1'b1;
    ar_if.aid    = id;
    ar_if.aaddr  = addr;
    ar_if.alen   = len;
    while (!hs && guard < 100) begin
      #1 hs = ar_if.aready;
      @(posedge clk);
      #1 guard++;
    end
    ar_if.avalid = 1'b0;
    check("handshake", hs, 1);
    if (hs) model_burst(id, addr, len);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk);
      #1 guard++;
    end
    check({name, "_idle"}, busy, 0);
    @(negedge clk);
    #1 check({name, "_drain"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_first_hdr(input string name);
    int guard;
    guard = 0;
    while (!hdr_fifo_wren && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    check({name, "_first"}, hdr_fifo_wren, 1);
  endtask

  task automatic pin(input string name, input int idx, input int len_dw, input logic [63:0] addr,
                     input int tag, input bit last);
    ent_t e;
    if (idx >= obs_q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d headers want header %0d", name, obs_q.size(), idx);
    end else begin
      e = obs_q[idx];
      check({name, "_len"}, e.hdr[9:0], len_dw);
      check({name, "_addr"}, {e.hdr[95:64], e.hdr[127:96]}, addr);
      check({name, "_tag"}, e.hdr[47:40], tag);
      check({name, "_ttag"}, e.td[TW:1], tag);
      check({name, "_last"}, e.td[0], last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hdr_fifo_afull = 1'b0;
    auto_release = 1'b1;
    man_release = 1'b0;
    ar_if.avalid = 1'b0;
    ar_if.aid = '0;
    ar_if.aaddr = '0;
    ar_if.alen = '0;
    repeat (3) @(posedge clk);
    #1 check("aready_in_rst", ar_if.aready, 0);
    rst = 1'b0;
    #1 check("aready_after_rst", ar_if.aready, 1);
    @(posedge clk);
    #1;

    // Single-header burst with first-issue latency.
    send_ar(4'h3, 64'h1000, 8'd3);
    check("lat_e1", hdr_fifo_wren, 0);
    check("lat_busy", busy, 1);
    @(posedge clk);
    #1 check("lat_e2", hdr_fifo_wren, 1);
    wait_idle("t1");
    check("t1_count", obs_q.size(), 1);
    pin("t1", 0, 32, 64'h1000, 0, 1'b1);
    if (obs_q.size() > 0) begin
      check("t1_dw0", obs_q[0].hdr[31:0], 32'h2000_0020);
      check("t1_dw1", obs_q[0].hdr[63:32], 32'hBEEF_00FF);
      check("t1_aid", obs_q[0].td[TDW-1:TW+1], 4'h3);
    end

    // MRRS split into three chunks at one header per cycle.
    reset_dut();
    send_ar(4'h5, 64'h1080, 8'd15);
    wait_idle("t2");
    check("t2_count", obs_q.size(), 3);
    pin("t2a", 0, 32, 64'h1080, 0, 1'b0);
    pin("t2b", 1, 64, 64'h1100, 1, 1'b0);
    pin("t2c", 2, 32, 64'h1200, 2, 1'b1);
    if (obs_cyc.size() == 3) check("t2_rate", obs_cyc[2] - obs_cyc[0], 2);

    // 4 KB boundary; tags continue from the previous burst.
    obs_q.delete();
    obs_cyc.delete();
    send_ar(4'h9, 64'h0FE0, 8'd1);
    wait_idle("t3");
    check("t3_count", obs_q.size(), 2);
    pin("t3a", 0, 8, 64'h0FE0, 3, 1'b0);
    pin("t3b", 1, 8, 64'h1000, 4, 1'b1);

    // FIFO almost-full back-pressure after the first header.
    reset_dut();
    send_ar(4'h1, 64'h1080, 8'd15);
    wait_first_hdr("t4");
    hdr_fifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("t4_stall", hdr_fifo_wren, 0);
    end
    check("t4_busy", busy, 1);
    hdr_fifo_afull = 1'b0;
    wait_idle("t4");
    check("t4_count", obs_q.size(), 3);
    pin("t4b", 1, 64, 64'h1100, 1, 1'b0);
    pin("t4c", 2, 32, 64'h1200, 2, 1'b1);

    // Reset mid-burst abandons the rest; next burst restarts at tag 0.
    reset_dut();
    send_ar(4'h2, 64'h1080, 8'd15);
    wait_first_hdr("t5");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("t5_aready", ar_if.aready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("t5_quiet", hdr_fifo_wren, 0);
    end
    check("t5_count", obs_q.size(), 1);
    send_ar(4'h7, 64'h2000, 8'd0);
    wait_idle("t5");
    check("t5_count2", obs_q.size(), 2);
    pin("t5n", 1, 8, 64'h2000, 0, 1'b1);

    // Back-to-back bursts leave one idle cycle between headers.
    obs_q.delete();
    obs_cyc.delete();
    send_ar(4'h4, 64'h3000, 8'd3);
    send_ar(4'h6, 64'h4000, 8'd3);
    wait_idle("t6");
    check("t6_count", obs_q.size(), 2);
    if (obs_cyc.size() == 2) check("t6_gap", obs_cyc[1] - obs_cyc[0], 2);

`ifdef AR_MRD_TAG_CREDIT_EN
    // Two credits: stall after two headers until one tag is released.
    auto_release = 1'b0;
    reset_dut();
    send_ar(4'h5, 64'h1080, 8'd15);
    repeat (8) @(posedge clk);
    #1 check("t7_stall_count", obs_q.size(), 2);
    check("t7_stall_busy", busy, 1);
    man_release = 1'b1;
    @(posedge clk);
    #1 man_release = 1'b0;
    wait_idle("t7");
    check("t7_count", obs_q.size(), 3);
    pin("t7c", 2, 32, 64'h1200, 2, 1'b1);
    auto_release = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_mrd_splitter.md
AR_MRD_SPLITTER -- requirements
Module: ar_mrd_splitter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default PCIE_PKG::ADDR_WIDTH, the AXI/TLP address width (at most 64).
REQ-002 SHALL have parameter ID_WIDTH, default 4, the AXI ARID width.
REQ-003 SHALL have parameter BEAT_BYTES, default 32, the bytes per AXI beat (power of two).
REQ-004 SHALL have parameter MRRS_BYTES, default 256, the max read request size (power of two, 64..4096).
REQ-005 SHALL have parameter TAG_WIDTH, default 8, the TLP tag width (at most 8).
REQ-006 SHALL have parameter REQ_ID, default 16'h0000, the requester ID placed in DW1.
REQ-007 SHALL have parameter TAG_CREDITS, default 32, the outstanding-tag limit (credit mode only).
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port ar_if, AXI4_A_IF.slave; it uses avalid, aready, aid, aaddr and alen[7:0].
REQ-011 SHALL have port hdr_fifo_afull, input, 1 bit: the header FIFO is almost full.
REQ-012 SHALL have port hdr_fifo_wren, output, 1 bit: header write strobe.
REQ-013 SHALL have port hdr_fifo_data, output, 128 bits: the MRd header.
REQ-014 SHALL have port tag_fifo_wren, output, 1 bit: tag-info write, coincident with hdr_fifo_wren.
REQ-015 SHALL have port tag_fifo_data, output, ID_WIDTH+TAG_WIDTH+1 bits: {aid, tag, last_of_burst}.
REQ-016 SHALL have port tag_release, input, 1 bit: one completion tag retired (credit mode only).
REQ-017 SHALL have port busy, output, 1 bit: state is SPLIT.

Function
REQ-018 SHALL use FSM states IDLE and SPLIT; ar_if.aready = (state==IDLE) && !rst.
REQ-019 SHALL, on an IDLE handshake, latch aid, cur_addr = aaddr with its low log2(BEAT_BYTES) bits cleared, and remaining = (alen+1)*BEAT_BYTES (14-bit, max 8192), then go to SPLIT.
REQ-020 SHALL, in SPLIT, form chunk = min(remaining, MRRS_BYTES - cur_addr mod MRRS_BYTES); since MRRS_BYTES divides 4096, no chunk crosses a 4 KB boundary.
REQ-021 SHALL define issue = SPLIT && !hdr_fifo_afull && credit_ok (credit_ok is 1 when credit mode is off).
REQ-022 SHALL, on issue, register hdr_fifo_wren=1 and tag_fifo_wren=1 for exactly one cycle, then advance cur_addr += chunk, remaining -= chunk and tag += 1 (tag wraps modulo 2^TAG_WIDTH).
REQ-023 SHALL encode the header as follows: DW0=hdr[31:0], fmt=3'b001, type=5'b00000, length[9:0]=chunk/4 (1024 DW encodes as 0).
REQ-024 SHALL encode DW1=hdr[63:32] as {REQ_ID, tag zero-extended to 8 bits, last BE, first BE=4'hF}, with last BE=4'hF, or 4'h0 when length is 1 DW.
REQ-025 SHALL encode DW2=hdr[95:64] as address[63:32] (zero when ADDR_WIDTH<=32) and DW3=hdr[127:96] as {address[31:2], 2'b00}.
REQ-026 SHALL set last_of_burst=1 on the chunk where remaining==chunk and return to IDLE on that same edge.
REQ-027 SHALL issue its first header on the 2nd rising edge after the handshake edge; throughput is one header per cycle; back-to-back bursts have a one-cycle IDLE gap.
REQ-028 SHALL, while hdr_fifo_afull=1, hold all state and keep wren low, with no loss or duplication on release.
REQ-029 SHALL keep hdr_fifo_data and tag_fifo_data stable whenever wren=0.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, force state=IDLE, hdr_fifo_wren=0, tag_fifo_wren=0, hdr_fifo_data=0, tag_fifo_data=0, tag=0, remaining=0 and credits=TAG_CREDITS.
REQ-031 SHALL, when rst arrives mid-SPLIT, abandon the burst with no further headers; aready=0 during rst.

Configuration
REQ-032 SHALL, with AR_MRD_TAG_CREDIT_EN defined, keep a credit counter: decrement on issue, increment on tag_release, no change when both occur, saturate at TAG_CREDITS; credit_ok = credits!=0.
REQ-033 SHALL, without AR_MRD_TAG_CREDIT_EN, omit the credit counter, ignore tag_release and tie credit_ok to 1.

Verification
REQ-034 SHALL cover: aaddr=0x1000, alen=3 -> one header, length=32, addr=0x1000, tag=0, last=1.
REQ-035 SHALL cover: aaddr=0x1080, alen=15 -> 3 headers with length 32/64/32 at 0x1080/0x1100/0x1200, tags 0/1/2, last only on the third.
REQ-036 SHALL cover: aaddr=0x0FE0, alen=1 -> 2 headers, length 8 each, at 0x0FE0 and 0x1000 (4 KB split).
REQ-037 SHALL cover: the REQ-035 burst with afull=1 for 5 cycles after the first header -> headers 2 and 3 follow the release, exactly 3 headers in total.
REQ-038 SHALL cover: rst pulsed after the first header of the REQ-035 burst -> no more wren, aready=1 the next cycle, and the next burst uses tag 0.
REQ-039 SHALL cover: with the macro and TAG_CREDITS=2, the REQ-035 burst -> stall after 2 headers; one tag_release -> third header follows.
